// File: rtl/mcu_row_reader.sv
// -----------------------------------------------------------------------------
// mcu_row_reader
//
// Reads one completed MCU row (8 lines x width_pix pixels) out of the
// ingester's back buffer and streams it to the DCT stage in MCU order:
// MCU 0..NUM_MCU-1, each MCU as 64 pixels in raster order inside the 8x8.
// The MCUs are spread round-robin over num_ebr EBRs, so MCU m lives in EBR
// (m mod num_ebr) at word offset (m / num_ebr) * 64.
//
// Ports
//   i_clock              system clock
//   i_nreset             asynchronous active-low reset
//   i_frontbuffer_select ingester write bank (already synchronous to i_clock);
//                        any change means the other bank is complete
//   o_rd_bank            bank being read
//   o_rd_block_select    EBR index 0..num_ebr-1
//   o_rd_addr            EBR word address
//   o_rd_en              read strobe, i_rd_data is valid one cycle later
//   i_rd_data            muxed EBR read data
//   o_pix_data           output pixel
//   o_pix_valid          o_pix_data valid
//   i_pix_ready          downstream accepts on o_pix_valid && i_pix_ready
//   o_mcu_first          pixel is pixel 0 of its MCU
//   o_mcu_index          MCU number of the current pixel
//   o_row_done           one-cycle pulse after the last pixel is accepted
//   o_overrun            sticky: a buffer completed while a row was in progress
// -----------------------------------------------------------------------------
module mcu_row_reader #(
   parameter int width_pix = 320,
   parameter int num_ebr   = 5,
   parameter int ebr_size  = 512
) (
   input  logic       i_clock,
   input  logic       i_nreset,
   input  logic       i_frontbuffer_select,
   output logic       o_rd_bank,
   output logic [2:0] o_rd_block_select,
   output logic [8:0] o_rd_addr,
   output logic       o_rd_en,
   input  logic [7:0] i_rd_data,
   output logic [7:0] o_pix_data,
   output logic       o_pix_valid,
   input  logic       i_pix_ready,
   output logic       o_mcu_first,
   output logic [5:0] o_mcu_index,
   output logic       o_row_done,
   output logic       o_overrun
);

   localparam int NUM_MCU = width_pix / 8;
   localparam int NUM_PIX = 64 * NUM_MCU;
   // read counter: 6 bits of pixel-within-MCU, 6 bits of MCU number
   localparam int N_W     = 12;
   localparam int ADDR_W  = $clog2(ebr_size);
   // word offset of an MCU inside its EBR, in units of 64 pixels
   localparam int MDIV_W  = ADDR_W - 6;

   localparam logic [N_W-1:0] LAST_N     = N_W'(NUM_PIX - 1);
   localparam logic [2:0]     LAST_BLOCK = 3'(num_ebr - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic              r_fb_prev;
   logic              w_toggle;

   logic [N_W-1:0]    r_n;
   logic [2:0]        r_block;
   logic [MDIV_W-1:0] r_mdiv;

   logic              r_rd_bank;
   logic              r_pending;
   logic              r_overrun;
   logic              r_row_done;

   // metadata of the read currently in flight through the EBR
   logic              r_inflight;
   logic              r_meta_first;
   logic [5:0]        r_meta_index;

   // two-entry output FIFO
   logic [7:0]        r_fifo_data  [2];
   logic              r_fifo_first [2];
   logic [5:0]        r_fifo_index [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   logic              w_pop;
   logic [2:0]        w_level;
   logic              w_rd_en;
   logic              w_start;
   logic              w_row_end;

   assign w_toggle = (i_frontbuffer_select != r_fb_prev);
   assign w_pop    = o_pix_valid && i_pix_ready;

   // FIFO occupancy one cycle from now, counting the read already in flight.
   // Issuing only while this is below 2 means every issued read has a slot
   // waiting for it, which is what keeps the FIFO from overflowing.
   assign w_level  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_rd_en      = 1'b0;
      w_start      = 1'b0;
      w_row_end    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_toggle) begin
               w_start      = 1'b1;
               w_state_next = S_READ;
            end
         end
         S_READ: begin
            if (w_level < 3'd2) begin
               w_rd_en = 1'b1;
               if (r_n == LAST_N) begin
                  w_state_next = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // nothing in flight and the FIFO empties with this cycle's pop
            if (w_level == 3'd0) begin
               w_row_end = 1'b1;
               // a toggle landing on the completion cycle is treated as
               // already pending so the next row starts without a gap
               if (r_pending || w_toggle) begin
                  w_start      = 1'b1;
                  w_state_next = S_READ;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------ control / status regs
   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         r_fb_prev  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_pending  <= 1'b0;
         r_overrun  <= 1'b0;
         r_row_done <= 1'b0;
      end else begin
         r_fb_prev  <= i_frontbuffer_select;
         r_row_done <= w_row_end;
         // The completed bank is always the one not being written. On a
         // fresh toggle that equals the previous select value as well.
         if (w_start) begin
            r_rd_bank <= ~i_frontbuffer_select;
         end
         if (w_start && (r_state == S_DRAIN)) begin
            r_pending <= 1'b0;
         end else if (w_toggle && (r_state != S_IDLE)) begin
            r_pending <= 1'b1;
         end
         if (w_toggle && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------- read counters
   // r_block / r_mdiv track (MCU mod num_ebr) and (MCU / num_ebr) by
   // stepping once per completed MCU, avoiding a divider.
   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         r_n     <= '0;
         r_block <= '0;
         r_mdiv  <= '0;
      end else if (w_start) begin
         r_n     <= '0;
         r_block <= '0;
         r_mdiv  <= '0;
      end else if (w_rd_en) begin
         r_n <= r_n + 1'b1;
         if (r_n[5:0] == 6'd63) begin
            if (r_block == LAST_BLOCK) begin
               r_block <= '0;
               r_mdiv  <= r_mdiv + 1'b1;
            end else begin
               r_block <= r_block + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------ read-data pipeline
   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         r_inflight   <= 1'b0;
         r_meta_first <= 1'b0;
         r_meta_index <= '0;
      end else begin
         r_inflight   <= w_rd_en;
         r_meta_first <= (r_n[5:0] == 6'd0);
         r_meta_index <= r_n[11:6];
      end
   end

   // ---------------------------------------------------------- output FIFO
   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i]  <= '0;
            r_fifo_first[i] <= 1'b0;
            r_fifo_index[i] <= '0;
         end
      end else if (r_inflight) begin
         r_fifo_data[r_wr_ptr]  <= i_rd_data;
         r_fifo_first[r_wr_ptr] <= r_meta_first;
         r_fifo_index[r_wr_ptr] <= r_meta_index;
      end
   end

   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (r_inflight) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= w_level[1:0];
      end
   end

   // ------------------------------------------------------------- outputs
   assign o_rd_bank         = r_rd_bank;
   assign o_rd_block_select = r_block;
   assign o_rd_addr         = {r_mdiv, r_n[5:0]};
   assign o_rd_en           = w_rd_en;
   assign o_pix_valid       = (r_count != 2'd0);
   assign o_pix_data        = r_fifo_data[r_rd_ptr];
   assign o_mcu_first       = r_fifo_first[r_rd_ptr];
   assign o_mcu_index       = r_fifo_index[r_rd_ptr];
   assign o_row_done        = r_row_done;
   assign o_overrun         = r_overrun;

endmodule

// File: tb/tb_mcu_row_reader.sv
// -----------------------------------------------------------------------------
// tb_mcu_row_reader
//
// Scoreboard bench for mcu_row_reader. Each buffer toggle pushes the full
// expected row (computed from the MCU/EBR layout arithmetic) into a queue;
// a monitor on the falling edge pops and compares every accepted pixel,
// checks row_done timing, stall stability and the EBR address sequence.
// -----------------------------------------------------------------------------
module tb_mcu_row_reader;

   localparam int NUM_MCU = 40;
   localparam int NPIX    = 64 * NUM_MCU;
   localparam int NEBR    = 5;

   logic       clk = 1'b0;
   logic       nreset;
   logic       fbsel;
   logic       ready;
   logic       rd_bank;
   logic [2:0] blk;
   logic [8:0] addr;
   logic       rd_en;
   logic [7:0] rd_data;
   logic [7:0] pix_data;
   logic       pix_valid;
   logic       mcu_first;
   logic [5:0] mcu_index;
   logic       row_done;
   logic       overrun;

   always #5 clk = ~clk;

   mcu_row_reader #(
      .width_pix (320),
      .num_ebr   (NEBR),
      .ebr_size  (512)
   ) dut (
      .i_clock              (clk),
      .i_nreset             (nreset),
      .i_frontbuffer_select (fbsel),
      .o_rd_bank            (rd_bank),
      .o_rd_block_select    (blk),
      .o_rd_addr            (addr),
      .o_rd_en              (rd_en),
      .i_rd_data            (rd_data),
      .o_pix_data           (pix_data),
      .o_pix_valid          (pix_valid),
      .i_pix_ready          (ready),
      .o_mcu_first          (mcu_first),
      .o_mcu_index          (mcu_index),
      .o_row_done           (row_done),
      .o_overrun            (overrun)
   );

   typedef struct {
      logic [7:0] data;
      logic       first;
      logic [5:0] idx;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int n_cmp = 0;
   int n_bad = 0;
   int acc_cnt = 0;
   int row_pix = 0;
   int row_firsts = 0;
   int rd_cnt = 0;
   bit done_due = 0;
   int ready_mode = 0;

   logic [7:0] hold_data;
   logic       hold_first;
   logic [5:0] hold_idx;
   bit         hold = 0;

   // EBR contents: a function of bank, EBR index and word address
   function automatic logic [7:0] ebr_val(input logic bank, input int block, input logic [8:0] a);
      int v;
      v = ((block * 64 + int'(a[5:0])) ^ int'(a[8:6])) & 255;
      if (bank) v = v ^ 128;
      return 8'(v);
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Expected stream for one row: MCU m sits in EBR m%5 at offset (m/5)*64
   task automatic push_row(input logic bank);
      exp_t e;
      for (int m = 0; m < NUM_MCU; m++) begin
         for (int p = 0; p < 64; p++) begin
            e.data  = ebr_val(bank, m % NEBR, 9'((m / NEBR) * 64 + p));
            e.first = (p == 0);
            e.idx   = 6'(m);
            e.last  = (m == NUM_MCU - 1) && (p == 63);
            exp_q.push_back(e);
         end
      end
   endtask

   // Synchronous-read EBR model
   always @(posedge clk) begin
      if (rd_en) rd_data <= ebr_val(rd_bank, int'(blk), addr);
   end

   // ready driver
   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 1) ready = (($urandom % 4) != 0);
         else                 ready = 1'b1;
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!nreset) begin
         exp_q.delete();
         hold       = 0;
         done_due   = 0;
         row_pix    = 0;
         row_firsts = 0;
         rd_cnt     = 0;
      end else begin
         // read address sequence
         if (rd_en) begin
            check("rd_block", int'(blk), (rd_cnt / 64) % NEBR);
            check("rd_addr", int'(addr), (rd_cnt / (64 * NEBR)) * 64 + rd_cnt % 64);
            rd_cnt = (rd_cnt + 1) % NPIX;
         end
         // stalled pixel must hold
         if (hold) begin
            check("stall_valid", int'(pix_valid), 1);
            check("stall_data", int'(pix_data), int'(hold_data));
            check("stall_first", int'(mcu_first), int'(hold_first));
            check("stall_index", int'(mcu_index), int'(hold_idx));
         end
         hold       = pix_valid && !ready;
         hold_data  = pix_data;
         hold_first = mcu_first;
         hold_idx   = mcu_index;
         // row_done exactly one cycle after the last accept
         if (done_due || row_done) begin
            check("row_done", int'(row_done), int'(done_due));
            if (done_due && exp_q.size() > 0) check("restart_rd_en", int'(rd_en), 1);
            done_due = 0;
         end
         // accepted pixel
         if (pix_valid && ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pixel: got data=%0d idx=%0d, expected no pixel",
                        pix_data, mcu_index);
            end else begin
               mon_e = exp_q.pop_front();
               check("pix_data", int'(pix_data), int'(mon_e.data));
               check("mcu_first", int'(mcu_first), int'(mon_e.first));
               check("mcu_index", int'(mcu_index), int'(mon_e.idx));
               acc_cnt++;
               row_pix++;
               if (mcu_first) row_firsts++;
               if (mon_e.last) begin
                  done_due = 1;
                  check("row_pixels", row_pix, NPIX);
                  check("row_mcu_firsts", row_firsts, NUM_MCU);
                  row_pix    = 0;
                  row_firsts = 0;
               end
            end
         end
      end
   end

   task automatic wait_rows();
      int cyc;
      cyc = 0;
      while ((exp_q.size() != 0 || done_due) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 20000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL row_timeout: got %0d pixels left, expected 0", exp_q.size());
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_bank"}, int'(rd_bank), 0);
      check({tag, "_rd_block"}, int'(blk), 0);
      check({tag, "_rd_addr"}, int'(addr), 0);
      check({tag, "_rd_en"}, int'(rd_en), 0);
      check({tag, "_pix_data"}, int'(pix_data), 0);
      check({tag, "_pix_valid"}, int'(pix_valid), 0);
      check({tag, "_mcu_first"}, int'(mcu_first), 0);
      check({tag, "_mcu_index"}, int'(mcu_index), 0);
      check({tag, "_row_done"}, int'(row_done), 0);
      check({tag, "_overrun"}, int'(overrun), 0);
   endtask

   task automatic toggle_to(input logic v);
      @(posedge clk);
      #1;
      fbsel = v;
   endtask

   initial begin
      int start;
      int cyc;
      nreset = 1'b0;
      fbsel  = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      nreset = 1'b1;
      repeat (3) @(negedge clk);

      // Row 1: bank 0, ready always high, latency checks
      ready_mode = 0;
      toggle_to(1'b1);
      push_row(1'b0);
      @(negedge clk);
      check("lat_rd_en_t0", int'(rd_en), 0);
      @(negedge clk);
      check("lat_rd_en_t1", int'(rd_en), 1);
      check("first_rd_bank", int'(rd_bank), 0);
      check("first_rd_addr", int'(addr), 0);
      check("first_rd_block", int'(blk), 0);
      @(negedge clk);
      check("lat_valid_t2", int'(pix_valid), 0);
      @(negedge clk);
      check("lat_valid_t3", int'(pix_valid), 1);
      wait_rows();
      check("row1_overrun", int'(overrun), 0);

      // Row 2: bank 1, random backpressure
      ready_mode = 1;
      toggle_to(1'b0);
      push_row(1'b1);
      repeat (2) @(negedge clk);
      check("row2_rd_en", int'(rd_en), 1);
      check("row2_rd_bank", int'(rd_bank), 1);
      wait_rows();
      check("row2_overrun", int'(overrun), 0);

      // Overrun: toggle mid-row queues exactly one further row
      toggle_to(1'b1);
      push_row(1'b0);
      repeat (100) @(negedge clk);
      toggle_to(1'b0);
      repeat (3) @(negedge clk);
      check("overrun_set", int'(overrun), 1);
      repeat (200) @(negedge clk);
      toggle_to(1'b1);
      // queued row reads the bank not being written when it starts
      push_row(~fbsel);
      wait_rows();
      repeat (100) @(negedge clk);
      check("post_overrun_idle_valid", int'(pix_valid), 0);
      check("post_overrun_idle_rd_en", int'(rd_en), 0);
      check("overrun_sticky", int'(overrun), 1);

      // Reset at pixel 1000 of a row
      ready_mode = 0;
      toggle_to(1'b0);
      push_row(1'b1);
      start = acc_cnt;
      cyc = 0;
      while ((acc_cnt - start) < 1000 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("reached_pixel_1000", (acc_cnt - start) >= 1000 ? 1 : 0, 1);
      @(posedge clk);
      #2;
      nreset = 1'b0;
      #1;
      check_all_zero("midrow_reset");
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      repeat (50) @(negedge clk);
      check("post_reset_valid", int'(pix_valid), 0);
      check("post_reset_rd_en", int'(rd_en), 0);
      toggle_to(1'b1);
      push_row(1'b0);
      wait_rows();
      check("final_overrun", int'(overrun), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
